// File: rtl/wm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wm_pkg
//  Description : Shared washing-machine definitions: controller state codes,
//                phase-timer FSM encoding and a timed/untimed classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
package wm_pkg;

    // Controller state codes; 6 and 7 are unused and behave as untimed
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READY = 3'd1;
    localparam logic [2:0] ST_SOAK  = 3'd2;
    localparam logic [2:0] ST_WASH  = 3'd3;
    localparam logic [2:0] ST_RINSE = 3'd4;
    localparam logic [2:0] ST_SPIN  = 3'd5;

    // Phase-timer FSM encoding
    typedef enum logic [1:0] {
        IDLE_T = 2'd0,
        COUNT  = 2'd1,
        DONE   = 2'd2
    } timer_state_t;

    // True for the phases that wait on a timeout from the timer
    function automatic logic is_timed(input logic [2:0] code);
        return (code == ST_SOAK) || (code == ST_WASH) ||
               (code == ST_RINSE) || (code == ST_SPIN);
    endfunction

endpackage : wm_pkg
`default_nettype wire

// File: rtl/wm_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : wm_tick_gen
//  Description : Free-running prescaler producing one tick every PRESCALE
//                clocks. 'clear' restarts the count so the next tick lands
//                exactly PRESCALE clocks after the clear is released.
//  Revision    : 1.0 - initial release
// ============================================================================
module wm_tick_gen #(
    parameter int PRESCALE = 1000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int              DIV_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(PRESCALE - 1);
    localparam logic [DIV_W-1:0] STEP = DIV_W'(1);

    logic [DIV_W-1:0] div;

    // Clock divider: wraps at PRESCALE-1, forced to zero while cleared
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div <= '0;
        end else if (clear || (div == LAST)) begin
            div <= '0;
        end else begin
            div <= div + STEP;
        end
    end

    assign tick = (div == LAST);

endmodule : wm_tick_gen
`default_nettype wire

// File: rtl/wm_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : wm_phase_timer
//  Description : Phase-duration timer for the washing-machine controller.
//                Watches the controller state, loads a per-phase duration
//                scaled by the latched program level, and issues a one-cycle
//                sig_Time_Out pulse when the phase has elapsed.
//                Build option: WM_TIMER_PRESCALE_EN - when defined, one tick
//                is PRESCALE clocks (wm_tick_gen); otherwise one tick is one
//                clock and PRESCALE is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module wm_phase_timer
    import wm_pkg::*;
#(
    parameter int SOAK_BASE  = 8,
    parameter int WASH_BASE  = 12,
    parameter int RINSE_BASE = 6,
    parameter int SPIN_BASE  = 10,
    parameter int CNT_W      = 16,
    parameter int PRESCALE   = 1000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [2:0]       state,
    input  logic [5:0]       program_sel,
    output logic             sig_Time_Out,
    output logic             busy,
    output logic [CNT_W-1:0] remaining
);

    // Durations are formed three bits wider than the counter so that
    // base * level (level <= 6) can be detected as overflowing and saturated.
    localparam int               PW       = CNT_W + 3;
    localparam logic [PW-1:0]    SOAK_W   = PW'(SOAK_BASE);
    localparam logic [PW-1:0]    WASH_W   = PW'(WASH_BASE);
    localparam logic [PW-1:0]    RINSE_W  = PW'(RINSE_BASE);
    localparam logic [PW-1:0]    SPIN_W   = PW'(SPIN_BASE);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       LEVEL_1  = 3'd1;

    // One-hot program select to level 1..6; anything not exactly one-hot is level 1
    function automatic logic [2:0] decode_level(input logic [5:0] sel);
        logic [2:0] lvl;
        int         ones;
        lvl  = LEVEL_1;
        ones = 0;
        for (int k = 0; k < 6; k++) begin
            if (sel[k]) begin
                ones = ones + 1;
                lvl  = 3'(k + 1);
            end
        end
        return (ones == 1) ? lvl : LEVEL_1;
    endfunction

    // Phase base times level, saturated to the counter range, never zero
    function automatic logic [CNT_W-1:0] phase_duration(input logic [2:0] code,
                                                         input logic [2:0] lvl);
        logic [PW-1:0] base;
        logic [PW-1:0] prod;
        case (code)
            ST_SOAK:  base = SOAK_W;
            ST_WASH:  base = WASH_W;
            ST_RINSE: base = RINSE_W;
            ST_SPIN:  base = SPIN_W;
            default:  base = '0;
        endcase
        prod = base * {{CNT_W{1'b0}}, lvl};
        if (|prod[PW-1:CNT_W]) begin
            return CNT_MAX;
        end else if (prod == '0) begin
            return CNT_ONE;
        end else begin
            return prod[CNT_W-1:0];
        end
    endfunction

    timer_state_t     fsm;
    logic [2:0]       prev_state;
    logic [2:0]       level;
    logic [CNT_W-1:0] count;
    logic             pulse;
    logic             busy_r;

    logic             tick;
    logic             timed_now;
    logic             phase_change;
    logic             latch_level;
    logic [2:0]       level_eff;
    logic [CNT_W-1:0] load_value;

    assign timed_now    = is_timed(state);
    assign phase_change = timed_now && (state != prev_state);
    assign latch_level  = timed_now && (prev_state == ST_READY);

    // The level latched on READY->timed must already apply to that same load
    assign level_eff  = latch_level ? decode_level(program_sel) : level;
    assign load_value = phase_duration(state, level_eff);

`ifdef WM_TIMER_PRESCALE_EN
    logic clear_presc;

    // Restart the prescaler at every load and hold it idle outside COUNT
    assign clear_presc = (fsm != COUNT) || phase_change;

    wm_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear_presc),
        .tick    (tick)
    );
`else
    logic unused_prescale;

    assign unused_prescale = ^PRESCALE;
    assign tick            = 1'b1;
`endif

    // Previous controller state, used to detect phase entry
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_state <= ST_IDLE;
        end else begin
            prev_state <= state;
        end
    end

    // Program level: captured on READY->timed, dropped back to 1 in IDLE/READY
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level <= LEVEL_1;
        end else if (latch_level) begin
            level <= level_eff;
        end else if ((state == ST_IDLE) || (state == ST_READY)) begin
            level <= LEVEL_1;
        end
    end

    // Timer FSM with registered counter, busy flag and timeout pulse.
    // A phase change outranks expiry so a colliding edge reloads silently.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm    <= IDLE_T;
            count  <= '0;
            pulse  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (!timed_now) begin
                fsm    <= IDLE_T;
                count  <= '0;
                busy_r <= 1'b0;
            end else if (phase_change) begin
                fsm    <= COUNT;
                count  <= load_value;
                busy_r <= 1'b1;
            end else begin
                case (fsm)
                    COUNT: begin
                        if (tick) begin
                            if ((count == CNT_ONE) || (count == '0)) begin
                                fsm    <= DONE;
                                count  <= '0;
                                busy_r <= 1'b0;
                                pulse  <= 1'b1;
                            end else begin
                                count <= count - CNT_ONE;
                            end
                        end
                    end
                    DONE: begin
                        count  <= '0;
                        busy_r <= 1'b0;
                    end
                    default: begin
                        fsm    <= IDLE_T;
                        count  <= '0;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sig_Time_Out = pulse;
    assign busy         = busy_r;
    assign remaining    = count;

endmodule : wm_phase_timer
`default_nettype wire
